// File: rtl/tick_reset_gen_pkg.sv
// Shared defaults and types for the tick/reset sequencer.
package tick_reset_gen_pkg;

  localparam int unsigned NUM_CH_DEF    = 32'd2;
  localparam int unsigned DIV_W_DEF     = 32'd16;
  localparam int unsigned DELAY_BIT_DEF = 32'd15;
  localparam int unsigned DB_BITS_DEF   = 32'd16;

  typedef logic [DIV_W_DEF-1:0] div_t;

  localparam div_t DIV_INIT_DEF = 16'd500;

  // A load always arms the shadow; otherwise a pending update is consumed at the wrap.
  function automatic logic pend_next(input logic pend, input logic wrap, input logic load);
    return load | (pend & ~wrap);
  endfunction

endpackage

// File: rtl/tick_chan.sv
// One tick channel: wrap counter, active/shadow divisor, tick pulse and half-rate square wave.
module tick_chan
  import tick_reset_gen_pkg::*;
#(
  parameter int unsigned DIV_W    = DIV_W_DEF,
  parameter int unsigned DIV_INIT = DIV_INIT_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
  output logic             tick_out,
  output logic             half_out
);

  localparam logic [DIV_W-1:0] INIT_V  = DIV_W'(DIV_INIT);
  localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] div_act_r;
  logic [DIV_W-1:0] div_sh_r;
  logic             pend_r;
  logic             tick_r;
  logic             half_r;

  logic             wrap_s;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] act_d;
  logic [DIV_W-1:0] sh_d;
  logic             pend_d;
  logic             half_d;

  // Next-state: the active divisor only changes at a wrap, so a period is never cut short
  always_comb begin
    wrap_s = (cnt_r == div_act_r);
    cnt_d  = cnt_r + CNT_ONE;
    act_d  = div_act_r;
    sh_d   = div_sh_r;
    half_d = half_r;
    if (wrap_s) begin
      cnt_d  = {DIV_W{1'b0}};
      half_d = ~half_r;
      if (pend_r) begin
        act_d = div_sh_r;
      end else begin
        act_d = div_act_r;
      end
    end else begin
      cnt_d  = cnt_r + CNT_ONE;
      half_d = half_r;
    end
    if (div_load) begin
      sh_d = div_in;
    end else begin
      sh_d = div_sh_r;
    end
    pend_d = pend_next(pend_r, wrap_s, div_load);
  end

  // Channel state register with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_r     <= {DIV_W{1'b0}};
      div_act_r <= INIT_V;
      div_sh_r  <= INIT_V;
      pend_r    <= 1'b0;
      tick_r    <= 1'b0;
      half_r    <= 1'b0;
    end else begin
      cnt_r     <= cnt_d;
      div_act_r <= act_d;
      div_sh_r  <= sh_d;
      pend_r    <= pend_d;
      tick_r    <= wrap_s;
      half_r    <= half_d;
    end
  end

  assign tick_out = tick_r;
  assign half_out = half_r;

endmodule

// File: rtl/tick_reset_gen.sv
// Multi-channel tick generator and button-driven reset stretcher for the LED panel tops.
// Define TICK_RESET_GEN_DEBOUNCE_EN to build the button debouncer; otherwise the synchronised button feeds clr directly.
module tick_reset_gen
  import tick_reset_gen_pkg::*;
#(
  parameter int unsigned NUM_CH    = NUM_CH_DEF,
  parameter int unsigned DIV_W     = DIV_W_DEF,
  parameter int unsigned DIV_INIT  = DIV_INIT_DEF,
  parameter int unsigned DELAY_BIT = DELAY_BIT_DEF,
  parameter int unsigned DB_BITS   = DB_BITS_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    btn_in,
  input  logic [NUM_CH*DIV_W-1:0] div_in,
  input  logic [NUM_CH-1:0]       div_load,
  output logic [NUM_CH-1:0]       tick_out,
  output logic [NUM_CH-1:0]       half_out,
  output logic                    rst_out,
  output logic                    ready_out
);

  localparam logic [DELAY_BIT:0] DCNT_ONE = {{DELAY_BIT{1'b0}}, 1'b1};

  logic btn_meta_r;
  logic btn_sync_r;
  logic btn_db_s;
  logic clr_s;

  logic [DELAY_BIT:0] dcnt_r;
  logic [DELAY_BIT:0] dcnt_d;
  logic               rst_r;
  logic               rst_d;
  logic               ready_r;

  // Two-flop synchroniser for the raw button
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_meta_r <= 1'b0;
      btn_sync_r <= 1'b0;
    end else begin
      btn_meta_r <= btn_in;
      btn_sync_r <= btn_meta_r;
    end
  end

`ifdef TICK_RESET_GEN_DEBOUNCE_EN
  localparam logic [DB_BITS-1:0] DB_LAST = {DB_BITS{1'b1}};
  localparam logic [DB_BITS-1:0] DB_ONE  = {{(DB_BITS-1){1'b0}}, 1'b1};

  logic [DB_BITS-1:0] db_cnt_r;
  logic               btn_db_r;

  // Follow the synchronised button only after it has disagreed for a full window
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt_r <= {DB_BITS{1'b0}};
      btn_db_r <= 1'b0;
    end else if (btn_sync_r != btn_db_r) begin
      if (db_cnt_r == DB_LAST) begin
        db_cnt_r <= {DB_BITS{1'b0}};
        btn_db_r <= btn_sync_r;
      end else begin
        db_cnt_r <= db_cnt_r + DB_ONE;
        btn_db_r <= btn_db_r;
      end
    end else begin
      db_cnt_r <= {DB_BITS{1'b0}};
      btn_db_r <= btn_db_r;
    end
  end

  assign btn_db_s = btn_db_r;
`else
  assign btn_db_s = btn_sync_r;
`endif

  assign clr_s = reset | btn_db_s;

  // Stretcher: count clean cycles after clr, saturating once the delay bit sets
  always_comb begin
    dcnt_d = dcnt_r;
    rst_d  = 1'b1;
    if (clr_s) begin
      dcnt_d = {(DELAY_BIT+1){1'b0}};
      rst_d  = 1'b1;
    end else if (dcnt_r[DELAY_BIT]) begin
      dcnt_d = dcnt_r;
      rst_d  = 1'b0;
    end else begin
      dcnt_d = dcnt_r + DCNT_ONE;
      rst_d  = 1'b1;
    end
  end

  // Stretcher state and registered reset/ready outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      dcnt_r  <= {(DELAY_BIT+1){1'b0}};
      rst_r   <= 1'b1;
      ready_r <= 1'b0;
    end else begin
      dcnt_r  <= dcnt_d;
      rst_r   <= rst_d;
      ready_r <= ~rst_d;
    end
  end

  assign rst_out   = rst_r;
  assign ready_out = ready_r;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    tick_chan #(
      .DIV_W    (DIV_W),
      .DIV_INIT (DIV_INIT)
    ) u_chan (
      .clk      (clk),
      .clr      (clr_s),
      .div_in   (div_in[gi*DIV_W +: DIV_W]),
      .div_load (div_load[gi]),
      .tick_out (tick_out[gi]),
      .half_out (half_out[gi])
    );
  end

endmodule

// File: tb/tb_tick_reset_gen.sv
// Directed bench for tick_reset_gen with DIV_INIT=4, DELAY_BIT=3, DB_BITS=3.
module tb_tick_reset_gen;

  localparam int NUM_CH = 2;
  localparam int DIV_W  = 8;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    btn_in;
  logic [NUM_CH*DIV_W-1:0] div_in;
  logic [NUM_CH-1:0]       div_load;
  logic [NUM_CH-1:0]       tick_out;
  logic [NUM_CH-1:0]       half_out;
  logic                    rst_out;
  logic                    ready_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tick_reset_gen #(
    .NUM_CH    (NUM_CH),
    .DIV_W     (DIV_W),
    .DIV_INIT  (4),
    .DELAY_BIT (3),
    .DB_BITS   (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .div_in    (div_in),
    .div_load  (div_load),
    .tick_out  (tick_out),
    .half_out  (half_out),
    .rst_out   (rst_out),
    .ready_out (ready_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // After this returns, the next posedge is edge 1 with clr low.
  task automatic do_reset();
    reset    = 1'b1;
    btn_in   = 1'b0;
    div_load = 2'b00;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    btn_in   = 1'b0;
    div_in   = 16'h0000;
    div_load = 2'b00;
    step();
    step();
    step();
    checks++;
    if (tick_out !== 2'b00) begin
      errors++;
      $display("FAIL reset_tick got=%b want=00", tick_out);
    end
    checks++;
    if (half_out !== 2'b00) begin
      errors++;
      $display("FAIL reset_half got=%b want=00", half_out);
    end
    checks++;
    if (rst_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_rst got=%b want=1", rst_out);
    end
    checks++;
    if (ready_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got=%b want=0", ready_out);
    end
  endtask

  task automatic test_release();
    logic t;
    logic h;
    logic r;
    h = 1'b0;
    do_reset();
    for (int k = 1; k <= 22; k++) begin
      step();
      t = (k % 5 == 0);
      if (t) h = ~h;
      r = (k < 9);
      checks++;
      if ({tick_out, half_out, rst_out, ready_out} !== {t, t, h, h, r, ~r}) begin
        errors++;
        $display("FAIL release edge=%0d tick=%b half=%b rst=%b ready=%b want tick=%b%b half=%b%b rst=%b ready=%b",
                 k, tick_out, half_out, rst_out, ready_out, t, t, h, h, r, ~r);
      end
    end
  endtask

  task automatic test_load_mid();
    logic t0, t1, h0, h1;
    h0 = 1'b0;
    h1 = 1'b0;
    do_reset();
    step();
    div_in   = {8'd7, 8'd2};
    div_load = 2'b01;
    for (int k = 2; k <= 17; k++) begin
      step();
      if (k == 2) div_load = 2'b00;
      t0 = (k == 5) || (k > 5 && (k - 5) % 3 == 0);
      t1 = (k % 5 == 0);
      if (t0) h0 = ~h0;
      if (t1) h1 = ~h1;
      checks++;
      if ({tick_out, half_out} !== {t1, t0, h1, h0}) begin
        errors++;
        $display("FAIL load_mid edge=%0d tick=%b half=%b want tick=%b%b half=%b%b",
                 k, tick_out, half_out, t1, t0, h1, h0);
      end
    end
  endtask

  task automatic test_zero_wrap();
    logic t0, t1, h0, h1;
    h0 = 1'b0;
    h1 = 1'b0;
    do_reset();
    div_in   = {8'd0, 8'd0};
    div_load = 2'b01;
    for (int k = 1; k <= 22; k++) begin
      step();
      if (k == 1) div_load = 2'b00;
      if (k == 12) begin
        div_in   = {8'd0, 8'd3};
        div_load = 2'b01;
      end
      if (k == 13) div_load = 2'b00;
      t0 = (k >= 5 && k <= 14) || (k == 18) || (k == 22);
      t1 = (k % 5 == 0);
      if (t0) h0 = ~h0;
      if (t1) h1 = ~h1;
      checks++;
      if ({tick_out, half_out} !== {t1, t0, h1, h0}) begin
        errors++;
        $display("FAIL zero_wrap edge=%0d tick=%b half=%b want tick=%b%b half=%b%b",
                 k, tick_out, half_out, t1, t0, h1, h0);
      end
    end
  endtask

  task automatic test_button();
    int rise, fall, clr_lo, clr_hi, last;
    logic t, h, r;
`ifdef TICK_RESET_GEN_DEBOUNCE_EN
    rise = 17; fall = 39; clr_lo = 17; clr_hi = 30; last = 42;
`else
    rise = 3;  fall = 12; clr_lo = 3;  clr_hi = 3;  last = 20;
`endif
    h = 1'b0;
    do_reset();
    for (int k = 1; k <= 12; k++) step();
    checks++;
    if ({rst_out, ready_out} !== 2'b01) begin
      errors++;
      $display("FAIL button_pre rst/ready=%b%b want 01", rst_out, ready_out);
    end
    btn_in = 1'b1;
    for (int k = 1; k <= last; k++) begin
      step();
`ifdef TICK_RESET_GEN_DEBOUNCE_EN
      if (k == 5)  btn_in = 1'b0;
      if (k == 6)  btn_in = 1'b1;
      if (k == 20) btn_in = 1'b0;
`else
      if (k == 1)  btn_in = 1'b0;
`endif
      if (k >= clr_lo && k <= clr_hi) begin
        t = 1'b0;
        h = 1'b0;
      end else begin
        t = (k < clr_lo) ? ((12 + k) % 5 == 0) : ((k - clr_hi) % 5 == 0);
        if (t) h = ~h;
      end
      r = (k >= rise) && (k < fall);
      checks++;
      if ({tick_out, half_out, rst_out, ready_out} !== {t, t, h, h, r, ~r}) begin
        errors++;
        $display("FAIL button edge=%0d tick=%b half=%b rst=%b ready=%b want tick=%b%b half=%b%b rst=%b ready=%b",
                 k, tick_out, half_out, rst_out, ready_out, t, t, h, h, r, ~r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_load_mid();
    test_zero_wrap();
    test_button();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
